osd_rom_arbiter: RTL and testbench
==================================

# osd_rom_arbiter

Two-port read arbiter in front of the single-port character/bitmap OSD ROM (`osd_rom`, 2^ADDR_WIDTH x DATA_WIDTH, synchronous read). Port A is the real-time OSD pixel fetcher in the HDMI char overlay path and has fixed priority. Port B is a low-rate host/debug readback port with a req/gnt handshake. A starvation counter forces occasional B service. Returned data is steered to the owning port by a tag pipeline matched to the ROM read latency.

## Interface
Parameters:
- ADDR_WIDTH, 11, ROM address width
- DATA_WIDTH, 8, ROM data width
- RD_LATENCY, 1, ROM read latency in cycles. Legal values: 1 (OUTPUT_REG=0) or 2 (OUTPUT_REG=1).
- STARVE_LIMIT, 255, consecutive cycles B may wait before a forced grant. Range 1..255. Counter is 8 bits.

Ports:
- clk  in  1  clock. Everything is rising-edge.
- tb_rst  in  1  reset, asynchronous, active-high
- a_req  in  1  port A read request, single cycle per address
- a_addr  in  ADDR_WIDTH  port A address, sampled with a_req
- a_rdata  out  DATA_WIDTH  port A read data
- a_rvalid  out  1  a_rdata valid, 1-cycle pulse
- a_miss  out  1  pulse: an a_req in this cycle was dropped (forced B grant)
- b_req  in  1  port B request. Level signal held with b_addr until b_gnt.
- b_addr  in  ADDR_WIDTH  port B address
- b_gnt  out  1  pulse: B request accepted this cycle
- b_rdata  out  DATA_WIDTH  port B read data
- b_rvalid  out  1  b_rdata valid, 1-cycle pulse
- b_starve  out  1  high while the starvation counter is at STARVE_LIMIT
- rom_addr  out  ADDR_WIDTH  registered address to osd_rom.addr
- rom_rdata  in  DATA_WIDTH  from osd_rom.rd_data

## Operation
- **Arbitration.** Decided combinationally each cycle from a_req, b_req and the starvation state:
  - force = b_req & (starve_cnt == STARVE_LIMIT)
  - grant B if force, or if (b_req & ~a_req)
  - otherwise grant A if a_req
  - otherwise idle
- **Grant and a_miss.** b_gnt is asserted in the deciding cycle. a_miss = a_req & force.
- **Issue.** At the clock edge, rom_addr <= the granted address. rom_addr holds its value when idle.
- **Tag pipeline.** A shift register of {valid, owner}, depth RD_LATENCY+1, is loaded at the issue edge. The tag at the last stage aligns with rom_rdata. On a valid tag:
  - rom_rdata is registered into a_rdata or b_rdata.
  - The matching rvalid is pulsed.
  - The other port's rdata holds its previous value.
- **Starvation counter.**
  - Clears on any b_gnt or when b_req is low.
  - Increments while b_req & ~b_gnt.
  - Saturates at STARVE_LIMIT.
- **Back-to-back.** One grant per cycle; throughput is one read per cycle. B may be granted on consecutive cycles if b_req stays high with new addresses.
- **Width rule.** Addresses pass through unmodified. No wrap logic: address 2^ADDR_WIDTH-1 is a legal final address.

## Timing
- **Latency.** A request/grant in cycle T gives rvalid in cycle T+RD_LATENCY+2:
  - 3 cycles for RD_LATENCY=1
  - 4 cycles for RD_LATENCY=2
- **Order.** Results return in issue order. Port A rvalid spacing equals a_req spacing.
- **Reset values.** All outputs are 0: rom_addr, a_rdata, b_rdata, a_rvalid, b_rvalid, b_gnt, a_miss, b_starve. starve_cnt and all tags are also 0.
- **Reset mid-operation.** In-flight tags are cleared and no rvalid is produced for them. After release, the first grant is possible in the first clock cycle.
- **Simultaneous a_req & b_req, no force.** A is granted. b_gnt stays low and starve_cnt increments.
- **Simultaneous a_req & b_req with force.** B is granted and a_miss pulses. The A request is not retried.
- **b_req dropped before grant.** No grant; the counter clears.

## Test plan
- **A streaming, RD_LATENCY=1.** After reset release, a_req every cycle over addr 0..2047, ROM preloaded with data = addr[7:0] -> a_rvalid every cycle starting 3 cycles after the first a_req, a_rdata = addr[7:0] in order, with no gaps and no a_miss.
- **B alone.** b_req=1, b_addr=0x155 -> b_gnt in the same cycle; b_rvalid 3 cycles later with b_rdata=0x55; a_rvalid stays 0.
- **Starvation, STARVE_LIMIT=4.**
  - Stimulus: a_req held continuously, b_req=1 at addr 0x010.
  - b_gnt after 4 waiting cycles, in the cycle where starve_cnt=4.
  - a_miss pulses once in that cycle.
  - b_rvalid returns 0x10.
  - b_starve is high for exactly that cycle.
- **Mixed traffic, RD_LATENCY=2.** Interleaved a_req/b_req with A idle on alternate cycles -> each rvalid arrives 4 cycles after its grant and is routed to the correct port; the other port's rdata is unchanged.
- **Reset mid-flight.** Assert tb_rst asynchronously 1 cycle after 2 grants -> no rvalid is ever produced for them; all outputs are 0 within the reset cycle; normal operation resumes after release.

Source files
------------

// File: rtl/osd_rom_arbiter.sv
// osd_rom_arbiter
//   Two-port read arbiter in front of the single-port OSD character/bitmap ROM.
//   Port A (real-time pixel fetcher) has fixed priority. Port B (host/debug
//   readback) uses a req/gnt handshake. A saturating starvation counter forces a
//   B grant once B has waited STARVE_LIMIT cycles. Read data is steered back to
//   the owning port by a {valid, owner} tag pipeline matched to the ROM latency.
//
// Ports
//   clk, tb_rst         clock (rising edge) / async active-high reset
//   a_req, a_addr       port A single-cycle read request and address
//   a_rdata, a_rvalid   port A read data and 1-cycle valid pulse
//   a_miss              pulse: an A request was dropped by a forced B grant
//   b_req, b_addr       port B level request, held with address until b_gnt
//   b_gnt               pulse: B request accepted this cycle
//   b_rdata, b_rvalid   port B read data and 1-cycle valid pulse
//   b_starve            high while the starvation counter sits at STARVE_LIMIT
//   rom_addr            registered ROM address
//   rom_rdata           ROM read data, RD_LATENCY cycles after rom_addr
module osd_rom_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 8,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 255
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    output logic                  a_miss,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_gnt,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic                  b_starve,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata
);

    // One stage per cycle from the issue edge until rom_rdata is valid.
    localparam int          DEPTH = RD_LATENCY + 1;
    localparam logic [7:0]  LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]       starve_cnt;
    logic             force_b;
    logic             grant_a;
    logic             grant_b;
    logic [DEPTH-1:0] tag_valid;
    logic [DEPTH-1:0] tag_owner;   // 1 = port B

    // Grants are gated by reset so every output reads 0 while tb_rst is high,
    // even with requests pending on the inputs.
    always_comb begin
        force_b  = b_req & (starve_cnt == LIMIT);
        grant_b  = ~tb_rst & (force_b | (b_req & ~a_req));
        grant_a  = ~tb_rst & a_req & ~grant_b;
        b_gnt    = grant_b;
        a_miss   = ~tb_rst & a_req & force_b;
        b_starve = (starve_cnt == LIMIT);
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rom_addr <= '0;
        end else if (grant_b) begin
            rom_addr <= b_addr;
        end else if (grant_a) begin
            rom_addr <= a_addr;
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            tag_valid <= {tag_valid[DEPTH-2:0], grant_a | grant_b};
            tag_owner <= {tag_owner[DEPTH-2:0], grant_b};
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            a_rdata  <= '0;
            b_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= tag_valid[DEPTH-1] & ~tag_owner[DEPTH-1];
            b_rvalid <= tag_valid[DEPTH-1] &  tag_owner[DEPTH-1];
            if (tag_valid[DEPTH-1] & ~tag_owner[DEPTH-1]) begin
                a_rdata <= rom_rdata;
            end
            if (tag_valid[DEPTH-1] & tag_owner[DEPTH-1]) begin
                b_rdata <= rom_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            starve_cnt <= '0;
        end else if (~b_req | grant_b) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_osd_rom_arbiter.sv
// Bench for osd_rom_arbiter: two instances (RD_LATENCY 1 and 2, STARVE_LIMIT 4)
// share one stimulus stream; a cycle-indexed schedule of expected returns is
// built from the arbitration rules and compared every cycle.
module tb_osd_rom_arbiter;
    localparam int AW   = 11;
    localparam int DW   = 8;
    localparam int SL   = 4;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic tb_rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_req = 1'b0;
    logic          b_req = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [AW-1:0] b_addr = '0;

    logic [DW-1:0] a_rdata [2];
    logic [DW-1:0] b_rdata [2];
    logic [DW-1:0] rom_rdata [2];
    logic [AW-1:0] rom_addr [2];
    logic          a_rvalid [2];
    logic          b_rvalid [2];
    logic          a_miss [2];
    logic          b_gnt [2];
    logic          b_starve [2];
    logic [DW-1:0] r2a;

    osd_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .STARVE_LIMIT(SL)) dut1 (
        .clk(clk), .tb_rst(tb_rst),
        .a_req(a_req), .a_addr(a_addr), .a_rdata(a_rdata[0]), .a_rvalid(a_rvalid[0]), .a_miss(a_miss[0]),
        .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt[0]), .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]),
        .b_starve(b_starve[0]), .rom_addr(rom_addr[0]), .rom_rdata(rom_rdata[0])
    );

    osd_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .STARVE_LIMIT(SL)) dut2 (
        .clk(clk), .tb_rst(tb_rst),
        .a_req(a_req), .a_addr(a_addr), .a_rdata(a_rdata[1]), .a_rvalid(a_rvalid[1]), .a_miss(a_miss[1]),
        .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt[1]), .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]),
        .b_starve(b_starve[1]), .rom_addr(rom_addr[1]), .rom_rdata(rom_rdata[1])
    );

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return a[7:0];
    endfunction

    // ROM models: latency 1 for dut1, latency 2 (output register) for dut2.
    always @(posedge clk) begin
        rom_rdata[0] <= rom_fn(rom_addr[0]);
        r2a          <= rom_fn(rom_addr[1]);
        rom_rdata[1] <= r2a;
    end

    int            checks = 0;
    int            failures = 0;
    int            n = 0;
    int            w = 0;
    bit            last_gb = 1'b0;
    bit            exp_v [2][2][MAXC];
    logic [DW-1:0] exp_d [2][2][MAXC];
    logic [DW-1:0] hold [2][2];
    logic [AW-1:0] exp_rom = '0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[lat%0d] cycle %0d: got %0h expected %0h", tag, k + 1, n, obs, exp);
        end
    endtask

    task automatic chk_zero();
        for (int k = 0; k < 2; k++) begin
            chk("rst_rom_addr", k, 32'(rom_addr[k]), 0);
            chk("rst_a_rdata", k, 32'(a_rdata[k]), 0);
            chk("rst_b_rdata", k, 32'(b_rdata[k]), 0);
            chk("rst_a_rvalid", k, 32'(a_rvalid[k]), 0);
            chk("rst_b_rvalid", k, 32'(b_rvalid[k]), 0);
            chk("rst_b_gnt", k, 32'(b_gnt[k]), 0);
            chk("rst_a_miss", k, 32'(a_miss[k]), 0);
            chk("rst_b_starve", k, 32'(b_starve[k]), 0);
        end
    endtask

    task automatic model_reset();
        for (int c = n; c < n + 8 && c < MAXC; c++)
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) exp_v[k][p][c] = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) hold[k][p] = '0;
        w       = 0;
        exp_rom = '0;
        last_gb = 1'b0;
    endtask

    // Called just after a falling edge with this cycle's inputs applied.
    task automatic do_cycle();
        bit            fb, gb, ga;
        int            c;
        logic [AW-1:0] ad;
        #1;
        fb = b_req && (w == SL);
        gb = fb || (b_req && !a_req);
        ga = a_req && !gb;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++)
                if (exp_v[k][p][n]) hold[k][p] = exp_d[k][p][n];
            chk("b_gnt", k, 32'(b_gnt[k]), 32'(gb));
            chk("a_miss", k, 32'(a_miss[k]), 32'(a_req && fb));
            chk("b_starve", k, 32'(b_starve[k]), 32'(w == SL));
            chk("a_rvalid", k, 32'(a_rvalid[k]), 32'(exp_v[k][0][n]));
            chk("b_rvalid", k, 32'(b_rvalid[k]), 32'(exp_v[k][1][n]));
            chk("a_rdata", k, 32'(a_rdata[k]), 32'(hold[k][0]));
            chk("b_rdata", k, 32'(b_rdata[k]), 32'(hold[k][1]));
            chk("rom_addr", k, 32'(rom_addr[k]), 32'(exp_rom));
        end
        if (gb || ga) begin
            ad      = gb ? b_addr : a_addr;
            exp_rom = ad;
            for (int k = 0; k < 2; k++) begin
                c = n + (k + 1) + 2;
                exp_v[k][gb][c] = 1'b1;
                exp_d[k][gb][c] = rom_fn(ad);
            end
        end
        if (!b_req || gb) w = 0;
        else if (w < SL) w = w + 1;
        last_gb = gb;
        @(negedge clk);
        n++;
    endtask

    task automatic b_stim();
        if (!b_req || last_gb) begin
            b_req  = ($urandom_range(0, 2) == 0);
            b_addr = AW'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
            b_req = 1'b0;
        end
    endtask

    task automatic idle(input int cycles);
        a_req = 1'b0;
        b_req = 1'b0;
        for (int i = 0; i < cycles; i++) do_cycle();
    endtask

    initial begin
        // Reset from time zero
        @(negedge clk);
        chk_zero();
        @(negedge clk);
        tb_rst = 1'b0;

        // A streaming over the full address range, including the top address
        for (int i = 0; i < 2048; i++) begin
            a_req  = 1'b1;
            a_addr = AW'(i);
            do_cycle();
        end
        idle(6);

        // B alone
        b_req  = 1'b1;
        b_addr = 11'h155;
        do_cycle();
        idle(6);

        // Starvation: A held continuously, B waits until forced
        a_req  = 1'b1;
        b_req  = 1'b1;
        b_addr = 11'h010;
        for (int i = 0; i < 12; i++) begin
            a_addr = AW'($urandom);
            do_cycle();
            if (last_gb) b_req = 1'b0;
        end
        idle(6);

        // Mixed traffic with A idle on alternate cycles
        for (int i = 0; i < 400; i++) begin
            a_req  = (i % 2 == 0) && ($urandom_range(0, 3) != 0);
            a_addr = AW'($urandom);
            b_stim();
            do_cycle();
        end
        // Dense random traffic
        for (int i = 0; i < 300; i++) begin
            a_req  = ($urandom_range(0, 3) != 0);
            a_addr = AW'($urandom);
            b_stim();
            do_cycle();
        end
        idle(6);

        // Reset one cycle after two grants
        a_req  = 1'b1;
        a_addr = 11'h7ff;
        do_cycle();
        a_addr = 11'h123;
        do_cycle();
        b_req  = 1'b1;
        b_addr = 11'h044;
        #2 tb_rst = 1'b1;
        #1 chk_zero();
        model_reset();
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
        n++;
        chk_zero();
        @(negedge clk);
        n++;
        tb_rst = 1'b0;
        idle(8);

        for (int i = 0; i < 300; i++) begin
            a_req  = ($urandom_range(0, 1) == 1);
            a_addr = AW'($urandom);
            b_stim();
            do_cycle();
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
